// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the serializer / sequence-detector path.
//   state_t        : serializer FSM states (IDLE = no frame, SHIFT = frame
//                    in progress), one-bit encoding.
//   DATA_W_DEFAULT : default parallel word width.
// ---------------------------------------------------------------------------
package seq_pkg;

    localparam int DATA_W_DEFAULT = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/ser_shift_reg.sv
// ---------------------------------------------------------------------------
// ser_shift_reg
// Loadable MSB-first shift register with a modulo-FRAME_LEN bit counter.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset (register and counter to 0)
//   load    : capture ld_word (takes priority over adv for the register)
//   ld_word : frame to be shifted out, MSB first
//   adv     : one frame bit is consumed this cycle
//   msb     : current frame bit
//   last    : counter is on the final bit of the frame
// ---------------------------------------------------------------------------
module ser_shift_reg
    import seq_pkg::*;
#(
    parameter int FRAME_LEN = DATA_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [FRAME_LEN-1:0] ld_word,
    input  logic                 adv,
    output logic                 msb,
    output logic                 last
);

    localparam int CNT_W = $clog2(FRAME_LEN);

    logic [FRAME_LEN-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    assign msb  = sreg_q[FRAME_LEN-1];
    assign last = (cnt_q == CNT_W'(FRAME_LEN - 1));

    always_comb begin
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        // A load on the final bit replaces the register outright; the
        // counter wraps to 0 on that same edge, so the new frame starts
        // aligned without a separate clear.
        if (load) begin
            sreg_d = ld_word;
        end else if (adv) begin
            sreg_d = {sreg_q[FRAME_LEN-2:0], 1'b0};
        end
        if (adv) begin
            cnt_d = last ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/bit_serializer.sv
// ---------------------------------------------------------------------------
// bit_serializer
// Converts DATA_W-bit parallel words into an MSB-first serial stream with a
// valid/ready handshake on the parallel side.
//   clk        : rising-edge clock
//   reset      : asynchronous active-low reset
//   din        : parallel word
//   din_valid  : din holds a word
//   din_ready  : word is accepted at the next edge if din_valid is high
//   x          : serial bit (0 whenever x_valid is 0)
//   x_valid    : x carries a frame bit
//   frame_done : high during the final bit of each frame
// Optional macro BIT_SERIALIZER_PARITY_EN appends an even-parity bit after
// the data LSB (frame length DATA_W+1).
// ---------------------------------------------------------------------------
module bit_serializer
    import seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              x,
    output logic              x_valid,
    output logic              frame_done
);

`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int FRAME_LEN = DATA_W + 1;
`else
    localparam int FRAME_LEN = DATA_W;
`endif

    state_t               state_q, state_d;
    logic [FRAME_LEN-1:0] ld_word;
    logic                 accept;
    logic                 shifting;
    logic                 last_bit;
    logic                 sr_msb;
    logic                 sr_last;

`ifdef BIT_SERIALIZER_PARITY_EN
    assign ld_word = {din, ^din};
`else
    assign ld_word = din;
`endif

    ser_shift_reg #(
        .FRAME_LEN (FRAME_LEN)
    ) u_shift (
        .clk     (clk),
        .rst_n   (reset),
        .load    (accept),
        .ld_word (ld_word),
        .adv     (shifting),
        .msb     (sr_msb),
        .last    (sr_last)
    );

    always_comb begin
        state_d  = state_q;
        shifting = (state_q == SHIFT);
        last_bit = shifting & sr_last;
        // Ready on the final bit lets a new frame follow with no gap.
        din_ready = (state_q == IDLE) | last_bit;
        accept    = din_valid & din_ready;
        if (accept) begin
            state_d = SHIFT;
        end else if (last_bit) begin
            state_d = IDLE;
        end
        x_valid    = shifting;
        x          = shifting & sr_msb;
        frame_done = last_bit;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
module tb_bit_serializer;

    localparam int DW = 8;
`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int FLEN = DW + 1;
`else
    localparam int FLEN = DW;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] din = '0;
    logic          din_valid = 1'b0;
    logic          din_ready, x, x_valid, frame_done;

    always #5 clk = ~clk;

    bit_serializer #(.DATA_W(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .x          (x),
        .x_valid    (x_valid),
        .frame_done (frame_done)
    );

    int n_chk = 0;
    int n_err = 0;

    // Pending serial bits of accepted frames: {bit, is_last_of_frame}.
    logic [1:0] exp_q[$];
    logic obs_x, obs_xv, obs_fd, obs_rdy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        logic [FLEN-1:0] fb;
`ifdef BIT_SERIALIZER_PARITY_EN
        fb = {w, ^w};
`else
        fb = w;
`endif
        for (int k = FLEN - 1; k >= 0; k--) exp_q.push_back({fb[k], k == 0});
    endtask

    // One clock: check outputs against the pending-bit queue, then drive
    // inputs for the coming edge. Ready means at most one bit still pending.
    task automatic step(input logic v, input logic [DW-1:0] d);
        logic mrdy;
        logic [1:0] hd;
        @(negedge clk);
        obs_x = x; obs_xv = x_valid; obs_fd = frame_done; obs_rdy = din_ready;
        mrdy = (exp_q.size() <= 1);
        hd   = (exp_q.size() != 0) ? exp_q[0] : 2'b00;
        chk("x_valid", 32'(x_valid), 32'(exp_q.size() != 0));
        chk("x", 32'(x), 32'(hd[1]));
        chk("frame_done", 32'(frame_done), 32'(hd[0]));
        chk("din_ready", 32'(din_ready), 32'(mrdy));
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        if (v && mrdy) push_word(d);
        din_valid = v;
        din = d;
    endtask

    // Asserted right after a step; offers a word during reset that must be ignored.
    task automatic do_reset();
        reset = 1'b0;
        din_valid = 1'b1;
        din = DW'($urandom);
        #1;
        chk("rst_x_valid", 32'(x_valid), 0);
        chk("rst_x", 32'(x), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        exp_q.delete();
        @(negedge clk);
        chk("rst_no_accept", 32'(x_valid), 0);
        din_valid = 1'b0;
        reset = 1'b1;
    endtask

    // Non-overlapping Moore 1011 detector over an 8-bit stream, MSB first.
    function automatic int det_count(input logic [7:0] bits, output int first);
        int st = 0;
        int n = 0;
        first = -1;
        for (int i = 7; i >= 0; i--) begin
            case (st)
                0: st = bits[i] ? 1 : 0;
                1: st = bits[i] ? 1 : 2;
                2: st = bits[i] ? 3 : 0;
                3: st = bits[i] ? 4 : 2;
                default: st = bits[i] ? 1 : 0;
            endcase
            if (st == 4) begin
                n++;
                if (first < 0) first = 7 - i;
            end
        end
        return n;
    endfunction

    initial begin
        logic [7:0]  cap8;
        logic [15:0] v_x, v_xv, v_fd, v_rdy;
        logic [8:0]  cap9;
        int fd_cnt, fd_at, ndet, dfirst;

        // Reset held for 12 ns
        #1;
        chk("reset_x", 32'(x), 0);
        chk("reset_x_valid", 32'(x_valid), 0);
        chk("reset_frame_done", 32'(frame_done), 0);
        #11;
        reset = 1'b1;

        // Single frame 0xB6
        step(1'b1, 8'hB6);
        fd_cnt = 0; fd_at = 0; cap8 = '0;
        for (int c = 1; c <= FLEN; c++) begin
            step(1'b0, '0);
            if (c <= 8) cap8 = {cap8[6:0], obs_x};
            chk("b6_xv", 32'(obs_xv), 1);
            if (obs_fd) begin fd_cnt++; fd_at = c; end
        end
        chk("b6_bits", 32'(cap8), 32'h0000_00B6);
        chk("b6_fd_count", 32'(fd_cnt), 1);
        chk("b6_fd_pos", 32'(fd_at), 32'(FLEN));
        step(1'b0, '0);
        chk("b6_idle_after", 32'(obs_xv), 0);

        // End-to-end through a 1011 detector
        ndet = det_count(cap8, dfirst);
        chk("det_count", 32'(ndet), 1);
        chk("det_after_bit4", 32'(dfirst), 3);

`ifndef BIT_SERIALIZER_PARITY_EN
        // Back-to-back 0xB6 then 0x0B with din_valid held
        step(1'b1, 8'hB6);
        for (int c = 1; c <= 16; c++) begin
            step(c <= 8, (c <= 8) ? 8'h0B : 8'h00);
            v_x[16-c] = obs_x; v_xv[16-c] = obs_xv;
            v_fd[16-c] = obs_fd; v_rdy[16-c] = obs_rdy;
        end
        chk("b2b_x", 32'(v_x), 32'hB60B);
        chk("b2b_xv", 32'(v_xv), 32'hFFFF);
        chk("b2b_fd", 32'(v_fd), 32'h0101);
        chk("b2b_rdy", 32'(v_rdy), 32'h0101);
        step(1'b0, '0);
`else
        // Parity frames
        step(1'b1, 8'hB0);
        fd_at = 0; cap9 = '0;
        for (int c = 1; c <= 9; c++) begin
            step(1'b0, '0);
            cap9 = {cap9[7:0], obs_x};
            if (obs_fd) fd_at = c;
        end
        chk("par_b0_bits", 32'(cap9), 32'h161);
        chk("par_b0_fd", 32'(fd_at), 9);
        step(1'b1, 8'hB4);
        cap9 = '0;
        for (int c = 1; c <= 9; c++) begin
            step(1'b0, '0);
            cap9 = {cap9[7:0], obs_x};
        end
        chk("par_b4_bits", 32'(cap9), 32'h168);
`endif

        // Mid-frame reset after 3 bits of 0xFF
        step(1'b1, 8'hFF);
        for (int c = 0; c < 3; c++) step(1'b0, '0);
        do_reset();
        step(1'b0, '0);
        chk("post_rst_ready", 32'(obs_rdy), 1);
        for (int c = 0; c < 10; c++) step(1'b0, '0);

        // Idle for 20 cycles
        for (int c = 0; c < 20; c++) step(1'b0, '0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) do_reset();
            else step($urandom_range(0, 3) != 0, DW'($urandom));
        end
        for (int c = 0; c < FLEN + 2; c++) step(1'b0, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
